// File: rtl/cafe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cafe_pkg
// Purpose  : Shared definitions for the coffee-machine payment front-end:
//            coin codes, coin value table, FSM state encoding and the
//            default money-register width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cafe_pkg;

  localparam int W_DINERO_DEF = 16;

  // Coin codes as seen on moneda_cod / cambio_cod
  localparam logic [1:0] COD_25  = 2'b00;
  localparam logic [1:0] COD_50  = 2'b01;
  localparam logic [1:0] COD_100 = 2'b10;
  localparam logic [1:0] COD_500 = 2'b11;

  localparam int VALOR_25  = 25;
  localparam int VALOR_50  = 50;
  localparam int VALOR_100 = 100;
  localparam int VALOR_500 = 500;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_COBRANDO    = 2'd1,
    S_PAGADO      = 2'd2,
    S_DEVOLVIENDO = 2'd3
  } estado_t;

  // Coin value table indexed by coin code
  function automatic int unsigned valor_moneda(input logic [1:0] cod);
    int unsigned v;
    case (cod)
      COD_25:  v = VALOR_25;
      COD_50:  v = VALOR_50;
      COD_100: v = VALOR_100;
      default: v = VALOR_500;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dispensador_cambio.sv
`default_nettype none
// ============================================================================
// Module   : dispensador_cambio
// Purpose  : Combinational greedy change selector. Picks the largest coin
//            not exceeding the amount still owed (500 > 100 > 50 > 25).
// Ports    : i_restante  in  W_DINERO  amount still to be returned
//            o_cod       out 2         code of the selected coin
//            o_valor     out W_DINERO  value of the selected coin (0 if none)
//            o_valido    out 1         a coin can be returned (i_restante>=25)
// Revision : 1.0 - initial release
// ============================================================================
module dispensador_cambio
  import cafe_pkg::*;
#(
  parameter int W_DINERO = W_DINERO_DEF
) (
  input  logic [W_DINERO-1:0] i_restante,
  output logic [1:0]          o_cod,
  output logic [W_DINERO-1:0] o_valor,
  output logic                o_valido
);

  always_comb begin
    o_cod    = COD_25;
    o_valor  = '0;
    o_valido = 1'b1;
    if (i_restante >= W_DINERO'(VALOR_500)) begin
      o_cod   = COD_500;
      o_valor = W_DINERO'(VALOR_500);
    end else if (i_restante >= W_DINERO'(VALOR_100)) begin
      o_cod   = COD_100;
      o_valor = W_DINERO'(VALOR_100);
    end else if (i_restante >= W_DINERO'(VALOR_50)) begin
      o_cod   = COD_50;
      o_valor = W_DINERO'(VALOR_50);
    end else if (i_restante >= W_DINERO'(VALOR_25)) begin
      o_cod   = COD_25;
      o_valor = W_DINERO'(VALOR_25);
    end else begin
      o_valido = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cajero_pago.sv
`default_nettype none
// ============================================================================
// Module   : cajero_pago
// Purpose  : Payment front-end. Latches the order price, accumulates coins,
//            pulses PAGO_RECIBIDO when paid and returns change (or the full
//            credit on cancel/timeout) one coin per cycle, greedy order.
// Ports    : clock, reset (async, active-high)
//            inicio_pedido / precio_real   order start and its price
//            moneda_in / moneda_cod        coin insertion
//            cancelar                      user abort
//            PAGO_RECIBIDO                 paid pulse
//            credito                       current credit
//            cambio_moneda / cambio_cod    returned coin pulse and code
//            moneda_rechazada              coin refused pulse
//            error_timeout                 refund-by-timeout pulse
//            ocupado                       not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module cajero_pago
  import cafe_pkg::*;
#(
  parameter int W_DINERO       = W_DINERO_DEF,
  parameter int TIMEOUT_CICLOS = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inicio_pedido,
  input  logic [W_DINERO-1:0] precio_real,
  input  logic                moneda_in,
  input  logic [1:0]          moneda_cod,
  input  logic                cancelar,
  output logic                PAGO_RECIBIDO,
  output logic [W_DINERO-1:0] credito,
  output logic                cambio_moneda,
  output logic [1:0]          cambio_cod,
  output logic                moneda_rechazada,
  output logic                error_timeout,
  output logic                ocupado
);

  localparam int TIMER_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TIMER_W-1:0] TIMER_FIN = TIMER_W'(TIMEOUT_CICLOS - 1);
  localparam logic [W_DINERO:0]  CREDITO_MAX = {1'b0, {W_DINERO{1'b1}}};

  estado_t               estado_q, estado_d;
  logic [W_DINERO-1:0]   precio_q, precio_d;
  logic [W_DINERO-1:0]   credito_q, credito_d;
  logic [W_DINERO-1:0]   restante_q, restante_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic                  pago_q, pago_d;
  logic                  cambio_q, cambio_d;
  logic [1:0]            cod_q, cod_d;
  logic                  rechazada_q, rechazada_d;
  logic                  timeout_q, timeout_d;
  logic                  ocupado_q, ocupado_d;

  logic [W_DINERO:0]     w_suma;
  logic [W_DINERO-1:0]   w_credito_sumado;
  logic [W_DINERO-1:0]   w_fuente;
  logic [1:0]            w_cod;
  logic [W_DINERO-1:0]   w_valor;
  logic                  w_valido;
  logic                  w_emitir;

  // Saturating credit update for the coin offered this cycle
  assign w_suma = {1'b0, credito_q} + (W_DINERO + 1)'(valor_moneda(moneda_cod));
  assign w_credito_sumado = (w_suma > CREDITO_MAX) ? '1 : w_suma[W_DINERO-1:0];

  // Amount fed to the change selector: the change owed when leaving PAGADO,
  // the whole credit when refunding from COBRANDO, otherwise what is left.
  always_comb begin
    case (estado_q)
      S_PAGADO:   w_fuente = credito_q - precio_q;
      S_COBRANDO: w_fuente = credito_q;
      default:    w_fuente = restante_q;
    endcase
  end

  dispensador_cambio #(
    .W_DINERO (W_DINERO)
  ) u_dispensador (
    .i_restante (w_fuente),
    .o_cod      (w_cod),
    .o_valor    (w_valor),
    .o_valido   (w_valido)
  );

  always_comb begin
    estado_d    = estado_q;
    precio_d    = precio_q;
    credito_d   = credito_q;
    restante_d  = restante_q;
    timer_d     = timer_q;
    cambio_d    = 1'b0;
    cod_d       = COD_25;
    rechazada_d = 1'b0;
    timeout_d   = 1'b0;
    w_emitir    = 1'b0;

    case (estado_q)
      S_IDLE: begin
        rechazada_d = moneda_in;
        if (inicio_pedido) begin
          precio_d   = precio_real;
          credito_d  = '0;
          restante_d = '0;
          timer_d    = '0;
          estado_d   = (precio_real == '0) ? S_PAGADO : S_COBRANDO;
        end
      end
      S_COBRANDO: begin
        // Priority: cancel, then coin, then timeout
        if (cancelar) begin
          rechazada_d = moneda_in;
          w_emitir    = 1'b1;
        end else if (moneda_in) begin
          credito_d = w_credito_sumado;
          timer_d   = '0;
          if (w_credito_sumado >= precio_q) estado_d = S_PAGADO;
        end else if (timer_q == TIMER_FIN) begin
          timeout_d = 1'b1;
          w_emitir  = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_PAGADO: begin
        rechazada_d = moneda_in;
        w_emitir    = 1'b1;
      end
      default: begin
        rechazada_d = moneda_in;
        w_emitir    = 1'b1;
      end
    endcase

    // Change/refund step shared by PAGADO, DEVOLVIENDO and cancel/timeout.
    // The first coin is issued on entry to DEVOLVIENDO so that change starts
    // the cycle after PAGO_RECIBIDO. A residue below the smallest coin only
    // gets a DEVOLVIENDO cycle when entered that way; it is then forfeited.
    if (w_emitir) begin
      if (w_valido) begin
        estado_d   = S_DEVOLVIENDO;
        cambio_d   = 1'b1;
        cod_d      = w_cod;
        restante_d = w_fuente - w_valor;
        credito_d  = w_fuente - w_valor;
      end else if ((w_fuente != '0) && (estado_q != S_DEVOLVIENDO)) begin
        estado_d   = S_DEVOLVIENDO;
        restante_d = w_fuente;
        credito_d  = w_fuente;
      end else begin
        estado_d   = S_IDLE;
        restante_d = '0;
        credito_d  = '0;
      end
    end

    pago_d    = (estado_d == S_PAGADO);
    ocupado_d = (estado_d != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= S_IDLE;
      precio_q    <= '0;
      credito_q   <= '0;
      restante_q  <= '0;
      timer_q     <= '0;
      pago_q      <= 1'b0;
      cambio_q    <= 1'b0;
      cod_q       <= COD_25;
      rechazada_q <= 1'b0;
      timeout_q   <= 1'b0;
      ocupado_q   <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      precio_q    <= precio_d;
      credito_q   <= credito_d;
      restante_q  <= restante_d;
      timer_q     <= timer_d;
      pago_q      <= pago_d;
      cambio_q    <= cambio_d;
      cod_q       <= cod_d;
      rechazada_q <= rechazada_d;
      timeout_q   <= timeout_d;
      ocupado_q   <= ocupado_d;
    end
  end

  assign PAGO_RECIBIDO    = pago_q;
  assign credito          = credito_q;
  assign cambio_moneda    = cambio_q;
  assign cambio_cod       = cod_q;
  assign moneda_rechazada = rechazada_q;
  assign error_timeout    = timeout_q;
  assign ocupado          = ocupado_q;

endmodule
`default_nettype wire

// File: tb/tb_cajero_pago.sv
`default_nettype none
// ============================================================================
// Module   : tb_cajero_pago
// Purpose  : Directed self-checking bench for cajero_pago (timeout set to 16).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_cajero_pago;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         inicio_pedido = 1'b0;
  logic [W-1:0] precio_real = '0;
  logic         moneda_in = 1'b0;
  logic [1:0]   moneda_cod = 2'b00;
  logic         cancelar = 1'b0;
  logic         PAGO_RECIBIDO;
  logic [W-1:0] credito;
  logic         cambio_moneda;
  logic [1:0]   cambio_cod;
  logic         moneda_rechazada;
  logic         error_timeout;
  logic         ocupado;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  cajero_pago #(
    .W_DINERO       (W),
    .TIMEOUT_CICLOS (16)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .inicio_pedido    (inicio_pedido),
    .precio_real      (precio_real),
    .moneda_in        (moneda_in),
    .moneda_cod       (moneda_cod),
    .cancelar         (cancelar),
    .PAGO_RECIBIDO    (PAGO_RECIBIDO),
    .credito          (credito),
    .cambio_moneda    (cambio_moneda),
    .cambio_cod       (cambio_cod),
    .moneda_rechazada (moneda_rechazada),
    .error_timeout    (error_timeout),
    .ocupado          (ocupado)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    inicio_pedido = 1'b0;
    moneda_in     = 1'b0;
    moneda_cod    = 2'b00;
    cancelar      = 1'b0;
  endtask

  task automatic start_order(input logic [W-1:0] p);
    precio_real   = p;
    inicio_pedido = 1'b1;
    tick();
    inicio_pedido = 1'b0;
  endtask

  task automatic coin(input logic [1:0] c);
    moneda_in  = 1'b1;
    moneda_cod = c;
    tick();
    moneda_in  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (credito !== 16'd0) begin
      n_err++; $display("FAIL reset_credito: got %0d expected 0", credito);
    end
    n_cmp++;
    if ({PAGO_RECIBIDO, cambio_moneda, cambio_cod, moneda_rechazada, error_timeout, ocupado} !== 7'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b expected 0000000",
        {PAGO_RECIBIDO, cambio_moneda, cambio_cod, moneda_rechazada, error_timeout, ocupado});
    end
    reset = 1'b0;
    tick();
  endtask

  // Price 350 paid exactly with 100,100,100,50
  task automatic test_exact_payment();
    logic [1:0] seq [4] = '{2'b10, 2'b10, 2'b10, 2'b01};
    int         acc [4] = '{100, 200, 300, 350};
    start_order(16'd350);
    n_cmp++;
    if (ocupado !== 1'b1 || credito !== 16'd0) begin
      n_err++; $display("FAIL exact_start: ocupado=%b credito=%0d expected 1/0", ocupado, credito);
    end
    for (int i = 0; i < 4; i++) begin
      coin(seq[i]);
      n_cmp++;
      if (credito !== 16'(acc[i]) || PAGO_RECIBIDO !== (i == 3)) begin
        n_err++; $display("FAIL exact_coin%0d: credito=%0d pago=%b expected %0d/%b",
          i, credito, PAGO_RECIBIDO, acc[i], (i == 3));
      end
    end
    n_cmp++;
    if (cambio_moneda !== 1'b0) begin
      n_err++; $display("FAIL exact_nochange_paid: cambio=%b expected 0", cambio_moneda);
    end
    tick();
    n_cmp++;
    if ({PAGO_RECIBIDO, cambio_moneda, ocupado} !== 3'b000 || credito !== 16'd0) begin
      n_err++; $display("FAIL exact_idle: pago/cambio/ocupado=%b credito=%0d expected 000/0",
        {PAGO_RECIBIDO, cambio_moneda, ocupado}, credito);
    end
  endtask

  // Price 275, coin 500 -> change 100,100,25
  task automatic test_change();
    logic [1:0] exp_cod  [3] = '{2'b10, 2'b10, 2'b00};
    int         exp_cred [3] = '{125, 25, 0};
    start_order(16'd275);
    coin(2'b11);
    n_cmp++;
    if (PAGO_RECIBIDO !== 1'b1 || credito !== 16'd500 || cambio_moneda !== 1'b0) begin
      n_err++; $display("FAIL change_paid: pago=%b credito=%0d cambio=%b expected 1/500/0",
        PAGO_RECIBIDO, credito, cambio_moneda);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (cambio_moneda !== 1'b1 || cambio_cod !== exp_cod[i] ||
          credito !== 16'(exp_cred[i]) || PAGO_RECIBIDO !== 1'b0) begin
        n_err++; $display("FAIL change_coin%0d: cambio=%b cod=%b credito=%0d pago=%b expected 1/%b/%0d/0",
          i, cambio_moneda, cambio_cod, credito, PAGO_RECIBIDO, exp_cod[i], exp_cred[i]);
      end
    end
    tick();
    n_cmp++;
    if (cambio_moneda !== 1'b0 || ocupado !== 1'b0 || credito !== 16'd0) begin
      n_err++; $display("FAIL change_end: cambio=%b ocupado=%b credito=%0d expected 0/0/0",
        cambio_moneda, ocupado, credito);
    end
  endtask

  // Price 400, coins 100,50, cancel -> refund 100,50, never paid
  task automatic test_cancel();
    logic seen_pago = 1'b0;
    start_order(16'd400);
    coin(2'b10);
    seen_pago |= PAGO_RECIBIDO;
    coin(2'b01);
    seen_pago |= PAGO_RECIBIDO;
    n_cmp++;
    if (credito !== 16'd150) begin
      n_err++; $display("FAIL cancel_credit: got %0d expected 150", credito);
    end
    cancelar = 1'b1;
    tick();
    cancelar = 1'b0;
    seen_pago |= PAGO_RECIBIDO;
    n_cmp++;
    if (cambio_moneda !== 1'b1 || cambio_cod !== 2'b10 || credito !== 16'd50) begin
      n_err++; $display("FAIL cancel_coin0: cambio=%b cod=%b credito=%0d expected 1/10/50",
        cambio_moneda, cambio_cod, credito);
    end
    tick();
    seen_pago |= PAGO_RECIBIDO;
    n_cmp++;
    if (cambio_moneda !== 1'b1 || cambio_cod !== 2'b01 || credito !== 16'd0) begin
      n_err++; $display("FAIL cancel_coin1: cambio=%b cod=%b credito=%0d expected 1/01/0",
        cambio_moneda, cambio_cod, credito);
    end
    tick();
    seen_pago |= PAGO_RECIBIDO;
    n_cmp++;
    if (cambio_moneda !== 1'b0 || ocupado !== 1'b0) begin
      n_err++; $display("FAIL cancel_end: cambio=%b ocupado=%b expected 0/0", cambio_moneda, ocupado);
    end
    n_cmp++;
    if (seen_pago !== 1'b0) begin
      n_err++; $display("FAIL cancel_no_pago: saw PAGO_RECIBIDO=%b expected 0", seen_pago);
    end
  endtask

  // Timeout 16: coin 25 then 16 idle cycles -> timeout, refund 25
  task automatic test_timeout();
    logic early = 1'b0;
    start_order(16'd100);
    coin(2'b00);
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (error_timeout !== 1'b0 || ocupado !== 1'b1) early = 1'b1;
    end
    n_cmp++;
    if (early !== 1'b0) begin
      n_err++; $display("FAIL timeout_early: premature timeout/exit flag=%b expected 0", early);
    end
    tick();
    n_cmp++;
    if (error_timeout !== 1'b1 || cambio_moneda !== 1'b1 || cambio_cod !== 2'b00 || credito !== 16'd0) begin
      n_err++; $display("FAIL timeout_fire: err=%b cambio=%b cod=%b credito=%0d expected 1/1/00/0",
        error_timeout, cambio_moneda, cambio_cod, credito);
    end
    tick();
    n_cmp++;
    if (error_timeout !== 1'b0 || cambio_moneda !== 1'b0 || ocupado !== 1'b0) begin
      n_err++; $display("FAIL timeout_end: err=%b cambio=%b ocupado=%b expected 0/0/0",
        error_timeout, cambio_moneda, ocupado);
    end
  endtask

  // Coin in IDLE rejected; cancel beats a simultaneous coin
  task automatic test_cancel_with_coin();
    coin(2'b11);
    n_cmp++;
    if (moneda_rechazada !== 1'b1 || credito !== 16'd0 || ocupado !== 1'b0) begin
      n_err++; $display("FAIL idle_coin: rech=%b credito=%0d ocupado=%b expected 1/0/0",
        moneda_rechazada, credito, ocupado);
    end
    start_order(16'd100);
    coin(2'b01);
    cancelar   = 1'b1;
    moneda_in  = 1'b1;
    moneda_cod = 2'b11;
    tick();
    quiet();
    n_cmp++;
    if (moneda_rechazada !== 1'b1 || cambio_moneda !== 1'b1 || cambio_cod !== 2'b01 ||
        credito !== 16'd0 || PAGO_RECIBIDO !== 1'b0) begin
      n_err++; $display("FAIL cancel_coin_refund: rech=%b cambio=%b cod=%b credito=%0d pago=%b expected 1/1/01/0/0",
        moneda_rechazada, cambio_moneda, cambio_cod, credito, PAGO_RECIBIDO);
    end
    tick();
    n_cmp++;
    if (cambio_moneda !== 1'b0 || ocupado !== 1'b0 || moneda_rechazada !== 1'b0) begin
      n_err++; $display("FAIL cancel_coin_end: cambio=%b ocupado=%b rech=%b expected 0/0/0",
        cambio_moneda, ocupado, moneda_rechazada);
    end
  endtask

  // Async reset in the middle of returning change, then a fresh order
  task automatic test_async_reset();
    start_order(16'd25);
    coin(2'b11);
    tick();
    tick();
    n_cmp++;
    if (cambio_moneda !== 1'b1 || cambio_cod !== 2'b10 || credito !== 16'd275) begin
      n_err++; $display("FAIL rst_prechange: cambio=%b cod=%b credito=%0d expected 1/10/275",
        cambio_moneda, cambio_cod, credito);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (credito !== 16'd0 || {PAGO_RECIBIDO, cambio_moneda, cambio_cod, moneda_rechazada, error_timeout, ocupado} !== 7'b0) begin
      n_err++; $display("FAIL rst_async: credito=%0d outs=%b expected 0/0000000", credito,
        {PAGO_RECIBIDO, cambio_moneda, cambio_cod, moneda_rechazada, error_timeout, ocupado});
    end
    tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if (ocupado !== 1'b0 || credito !== 16'd0) begin
      n_err++; $display("FAIL rst_idle: ocupado=%b credito=%0d expected 0/0", ocupado, credito);
    end
    start_order(16'd150);
    coin(2'b10);
    coin(2'b01);
    n_cmp++;
    if (PAGO_RECIBIDO !== 1'b1 || credito !== 16'd150) begin
      n_err++; $display("FAIL rst_neworder: pago=%b credito=%0d expected 1/150", PAGO_RECIBIDO, credito);
    end
    tick();
    n_cmp++;
    if (ocupado !== 1'b0 || cambio_moneda !== 1'b0) begin
      n_err++; $display("FAIL rst_neworder_end: ocupado=%b cambio=%b expected 0/0", ocupado, cambio_moneda);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_exact_payment();
    test_change();
    test_cancel();
    test_timeout();
    test_cancel_with_coin();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
